// File: rtl/v850_mem_pkg.sv
// Shared types and constants for the V850 pipeline to DDR3 user-interface arbiter.
// The beat is eight 32-bit lanes; the byte mask carries one bit per byte of the beat.
package v850_mem_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned BEAT_W = LANES * 32;
  localparam int unsigned MASK_W = LANES * 4;

  localparam logic [2:0] DDR_CMD_RD = 3'b001;
  localparam logic [2:0] DDR_CMD_WR = 3'b000;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StCmd,
    StWdata,
    StRwait,
    StAck
  } state_e;

  typedef enum logic {
    GNT_IF,
    GNT_MEM
  } grant_e;

endpackage

// File: rtl/v850_ddr_lane.sv
// Lane steering between the 32/64-bit pipeline ports and the 256-bit DDR beat:
// write replication and byte-mask generation, read lane/doubleword extraction.
module v850_ddr_lane
  import v850_mem_pkg::*;
(
  input  logic [2:0]        wr_lane,
  input  logic [31:0]       wr_word,
  input  logic [3:0]        wr_be,
  input  logic [2:0]        rd_lane,
  input  logic [1:0]        rd_dword_sel,
  input  logic [BEAT_W-1:0] rd_beat,
  output logic [BEAT_W-1:0] wr_beat,
  output logic [MASK_W-1:0] wr_mask,
  output logic [31:0]       rd_word,
  output logic [63:0]       rd_dword
);

  always_comb begin
    wr_beat = {LANES{wr_word}};
    wr_mask = '1;
    // Only the addressed lane is opened; a mask bit of 1 suppresses that byte.
    for (int i = 0; i < LANES; i++) begin
      if (wr_lane == 3'(i)) begin
        wr_mask[4*i +: 4] = ~wr_be;
      end
    end
    rd_word  = rd_beat[{rd_lane, 5'd0} +: 32];
    rd_dword = rd_beat[{rd_dword_sel, 6'd0} +: 64];
  end

endmodule

// File: rtl/v850_ddr_arbiter.sv
// Two-port arbiter and single-beat BL8 sequencer between the V850 fetch/memory
// stages and the DDR3 IP user interface. One transaction in flight; all outputs registered.
module v850_ddr_arbiter
  import v850_mem_pkg::*;
#(
  parameter int unsigned DDR_ADDR_W = 29,
  parameter int unsigned DDR_DATA_W = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_calib_complete,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_ack,
  output logic [63:0]           if_rdata,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_be,
  output logic                  mem_ack,
  output logic [31:0]           mem_rdata,
  output logic [2:0]            ddr_cmd,
  output logic                  ddr_en,
  input  logic                  ddr_rdy,
  output logic [DDR_ADDR_W-1:0] mem_addr_o,
  output logic [DDR_DATA_W-1:0] ddr_write_data,
  output logic                  ddr_write_en,
  output logic                  ddr_write_data_end,
  output logic [31:0]           app_wdf_mask,
  input  logic                  ddr_write_rdy,
  input  logic [DDR_DATA_W-1:0] ddr_read_data,
  input  logic                  ddr_read_data_valid,
  output logic                  app_burst
);

  state_e                state_q, state_d;
  grant_e                gnt_q, gnt_d;
  grant_e                last_q, last_d;
  logic                  we_q, we_d;
  logic [2:0]            rd_sel_q, rd_sel_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [DDR_ADDR_W-1:0] ddr_addr_q, ddr_addr_d;
  logic [DDR_DATA_W-1:0] wbeat_q, wbeat_d;
  logic [31:0]           mask_q, mask_d;
  logic [63:0]           if_rdata_q, if_rdata_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;
  logic                  en_q, en_d;
  logic                  wen_q, wen_d;
  logic                  if_ack_q, if_ack_d;
  logic                  mem_ack_q, mem_ack_d;

  logic                  pick_mem;
  logic [31:0]           sel_addr;
  logic [BEAT_W-1:0]     lane_wbeat;
  logic [MASK_W-1:0]     lane_mask;
  logic [31:0]           lane_word;
  logic [63:0]           lane_dword;
  logic                  unused_addr;

  v850_ddr_lane u_lane (
    .wr_lane      (mem_addr[4:2]),
    .wr_word      (mem_wdata),
    .wr_be        (mem_be),
    .rd_lane      (rd_sel_q),
    .rd_dword_sel (rd_sel_q[2:1]),
    .rd_beat      (ddr_read_data),
    .wr_beat      (lane_wbeat),
    .wr_mask      (lane_mask),
    .rd_word      (lane_word),
    .rd_dword     (lane_dword)
  );

  // Byte-offset bits and bit 31 play no part in the DDR column/row address.
  assign unused_addr = ^{sel_addr[31], sel_addr[1:0]};

  always_comb begin
    // On contention the port not served last wins.
    pick_mem    = mem_req && (!if_req || (last_q == GNT_IF));
    sel_addr    = pick_mem ? mem_addr : if_addr;

    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    we_d        = we_q;
    rd_sel_d    = rd_sel_q;
    cmd_d       = cmd_q;
    ddr_addr_d  = ddr_addr_q;
    wbeat_d     = wbeat_q;
    mask_d      = mask_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    unique case (state_q)
      StInit: begin
        if (init_calib_complete) state_d = StIdle;
      end
      StIdle: begin
        if (!init_calib_complete) begin
          state_d = StInit;
        end else if (if_req || mem_req) begin
          state_d    = StCmd;
          gnt_d      = pick_mem ? GNT_MEM : GNT_IF;
          we_d       = pick_mem && mem_we;
          rd_sel_d   = sel_addr[4:2];
          cmd_d      = (pick_mem && mem_we) ? DDR_CMD_WR : DDR_CMD_RD;
          ddr_addr_d = DDR_ADDR_W'({sel_addr[30:5], 3'b000});
          if (pick_mem && mem_we) begin
            wbeat_d = lane_wbeat;
            mask_d  = lane_mask;
          end
        end
      end
      StCmd: begin
        if (ddr_rdy) state_d = we_q ? StWdata : StRwait;
      end
      StWdata: begin
        if (ddr_write_rdy) state_d = StAck;
      end
      StRwait: begin
        if (ddr_read_data_valid) begin
          state_d = StAck;
          if (gnt_q == GNT_IF) if_rdata_d = lane_dword;
          else                 mem_rdata_d = lane_word;
        end
      end
      StAck: begin
        last_d  = gnt_q;
        state_d = StIdle;
      end
      default: state_d = StInit;
    endcase

    // Strobes are decoded from the next state so they appear registered.
    en_d      = (state_d == StCmd);
    wen_d     = (state_d == StWdata);
    if_ack_d  = (state_d == StAck) && (gnt_d == GNT_IF);
    mem_ack_d = (state_d == StAck) && (gnt_d == GNT_MEM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      gnt_q       <= GNT_IF;
      last_q      <= GNT_IF;
      we_q        <= 1'b0;
      rd_sel_q    <= '0;
      cmd_q       <= '0;
      ddr_addr_q  <= '0;
      wbeat_q     <= '0;
      mask_q      <= '1;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      en_q        <= 1'b0;
      wen_q       <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      we_q        <= we_d;
      rd_sel_q    <= rd_sel_d;
      cmd_q       <= cmd_d;
      ddr_addr_q  <= ddr_addr_d;
      wbeat_q     <= wbeat_d;
      mask_q      <= mask_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      en_q        <= en_d;
      wen_q       <= wen_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
    end
  end

  assign if_ack             = if_ack_q;
  assign if_rdata           = if_rdata_q;
  assign mem_ack            = mem_ack_q;
  assign mem_rdata          = mem_rdata_q;
  assign ddr_cmd            = cmd_q;
  assign ddr_en             = en_q;
  assign mem_addr_o         = ddr_addr_q;
  assign ddr_write_data     = wbeat_q;
  assign ddr_write_en       = wen_q;
  assign ddr_write_data_end = wen_q;
  assign app_wdf_mask       = mask_q;
  assign app_burst          = 1'b1;

endmodule

// File: tb/tb_v850_ddr_arbiter.sv
// Self-checking bench for v850_ddr_arbiter: table-driven transactions against a small
// DDR responder, a scoreboard of expected acks, and hand-written reset/arbitration sequences.
module tb_v850_ddr_arbiter;

  localparam logic [2:0] CMD_RD = 3'b001;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [255:0] BEAT = {32'h12345678, 32'h89ABCDEF, 32'h5A5A5A5A, 32'h4B4B4B4B,
                                   32'h3C3C3C3C, 32'h2D2D2D2D, 32'h1E1E1E1E, 32'h0F0F0F0F};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         init_calib_complete;
  logic         if_req;
  logic [31:0]  if_addr;
  logic         if_ack;
  logic [63:0]  if_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_be;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic [2:0]   ddr_cmd;
  logic         ddr_en;
  logic         ddr_rdy;
  logic [28:0]  mem_addr_o;
  logic [255:0] ddr_write_data;
  logic         ddr_write_en;
  logic         ddr_write_data_end;
  logic [31:0]  app_wdf_mask;
  logic         ddr_write_rdy;
  logic [255:0] ddr_read_data;
  logic         ddr_read_data_valid;
  logic         app_burst;

  typedef struct {
    bit          is_if;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          rdy_stall;
    int          wrdy_stall;
    int          rlat;
    logic [28:0] exp_addr;
    logic [31:0] exp_mask;
    logic [63:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          is_if;
    bit          is_wr;
    logic [63:0] data;
  } sb_t;

  vec_t vecs[9];
  sb_t  sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  v850_ddr_arbiter dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .if_req              (if_req),
    .if_addr             (if_addr),
    .if_ack              (if_ack),
    .if_rdata            (if_rdata),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_be              (mem_be),
    .mem_ack             (mem_ack),
    .mem_rdata           (mem_rdata),
    .ddr_cmd             (ddr_cmd),
    .ddr_en              (ddr_en),
    .ddr_rdy             (ddr_rdy),
    .mem_addr_o          (mem_addr_o),
    .ddr_write_data      (ddr_write_data),
    .ddr_write_en        (ddr_write_en),
    .ddr_write_data_end  (ddr_write_data_end),
    .app_wdf_mask        (app_wdf_mask),
    .ddr_write_rdy       (ddr_write_rdy),
    .ddr_read_data       (ddr_read_data),
    .ddr_read_data_valid (ddr_read_data_valid),
    .app_burst           (app_burst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit is_if, bit we, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] be, int rs, int ws, int rl, logic [28:0] ea,
                              logic [31:0] em, logic [63:0] er);
    vec_t v;
    v.is_if = is_if; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.rdy_stall = rs; v.wrdy_stall = ws; v.rlat = rl;
    v.exp_addr = ea; v.exp_mask = em; v.exp_rdata = er;
    return v;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_strobes"}, {ddr_en, ddr_write_en, ddr_write_data_end, if_ack, mem_ack,
                            app_burst}, 6'b000001);
    chk({tag, "_cmd"}, ddr_cmd, 3'b000);
    chk({tag, "_addr"}, mem_addr_o, 29'h0);
    chk({tag, "_mask"}, app_wdf_mask, 32'hFFFF_FFFF);
    chk({tag, "_wdata"}, ddr_write_data, 256'h0);
    chk({tag, "_if_rdata"}, if_rdata, 64'h0);
    chk({tag, "_mem_rdata"}, mem_rdata, 32'h0);
  endtask

  task automatic issue(input vec_t v);
    sb_t e;
    e.is_if = v.is_if;
    e.is_wr = v.we;
    e.data  = v.exp_rdata;
    sb.push_back(e);
    if (v.is_if) begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end else begin
      mem_req   = 1'b1;
      mem_we    = v.we;
      mem_addr  = v.addr;
      mem_wdata = v.wdata;
      mem_be    = v.be;
    end
  endtask

  // Plays the DDR IP for one transaction; exp_lat of 0 skips the grant-latency check.
  task automatic service(input vec_t v, input int exp_lat);
    int          cyc;
    logic [2:0]  exp_cmd;
    exp_cmd = v.we ? CMD_WR : CMD_RD;
    cyc = 0;
    while (!ddr_en && cyc < 40) begin
      tick();
      cyc++;
    end
    if (exp_lat > 0) chk("en_latency", cyc, exp_lat);
    chk("cmd_en", ddr_en, 1'b1);
    chk("cmd", ddr_cmd, exp_cmd);
    chk("cmd_addr", mem_addr_o, v.exp_addr);
    for (int k = 0; k < v.rdy_stall; k++) begin
      tick();
      chk("cmd_hold", {ddr_en, ddr_cmd, mem_addr_o}, {1'b1, exp_cmd, v.exp_addr});
    end
    ddr_rdy = 1'b1;
    tick();
    ddr_rdy = 1'b0;
    if (v.we) begin
      chk("wr_strobes", {ddr_write_en, ddr_write_data_end, ddr_en}, 3'b110);
      chk("wr_data", ddr_write_data, {8{v.wdata}});
      chk("wr_mask", app_wdf_mask, v.exp_mask);
      for (int k = 0; k < v.wrdy_stall; k++) begin
        tick();
        chk("wr_hold", {ddr_write_en, ddr_write_data_end, app_wdf_mask, ddr_write_data},
            {2'b11, v.exp_mask, {8{v.wdata}}});
      end
      ddr_write_rdy = 1'b1;
      tick();
      ddr_write_rdy = 1'b0;
    end else begin
      chk("rwait_quiet", {ddr_en, ddr_write_en}, 2'b00);
      for (int k = 0; k < v.rlat; k++) begin
        tick();
        chk("rwait_no_ack", {if_ack, mem_ack}, 2'b00);
      end
      ddr_read_data = BEAT;
      ddr_read_data_valid = 1'b1;
      tick();
      ddr_read_data_valid = 1'b0;
      ddr_read_data = ~BEAT;
    end
    chk("ack", {if_ack, mem_ack}, v.is_if ? 2'b10 : 2'b01);
    if_req  = 1'b0;
    mem_req = 1'b0;
    tick();
    chk("ack_pulse", {if_ack, mem_ack}, 2'b00);
  endtask

  // Scoreboard side: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (if_ack || mem_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {if_ack, mem_ack}, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("ack_port", {if_ack, mem_ack}, e.is_if ? 2'b10 : 2'b01);
        if (e.is_if) chk("if_rdata", if_rdata, e.data);
        else if (!e.is_wr) chk("mem_rdata", mem_rdata, e.data[31:0]);
      end
    end
  end

  initial begin
    sb_t e;
    int  n;
    rst_n = 1'b0; init_calib_complete = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
    ddr_rdy = 1'b0; ddr_write_rdy = 1'b0; ddr_read_data = '0; ddr_read_data_valid = 1'b0;

    //          if we addr           wdata          be       rs  ws rl exp_addr      mask
    vecs[0] = mk(1, 0, 32'h0000_2000, 32'h0,        4'b0000, 0,  0, 0, 29'h800,      '1,
                 64'h1E1E1E1E_0F0F0F0F);
    vecs[1] = mk(0, 1, 32'h0000_0014, 32'hDEADBEEF, 4'b0011, 0,  0, 0, 29'h0,
                 32'hFFCF_FFFF, 64'h0);
    vecs[2] = mk(0, 0, 32'h0000_001C, 32'h0,        4'b0000, 0,  0, 0, 29'h0,        '1,
                 64'h12345678);
    vecs[3] = mk(1, 0, 32'h0000_0018, 32'h0,        4'b0000, 0,  0, 2, 29'h0,        '1,
                 64'h12345678_89ABCDEF);
    vecs[4] = mk(0, 1, 32'h0000_0040, 32'hCAFEF00D, 4'b0000, 1,  2, 0, 29'h10,
                 32'hFFFF_FFFF, 64'h0);
    vecs[5] = mk(0, 1, 32'h8000_1008, 32'hA5C30F96, 4'b1111, 10, 10, 0, 29'h400,
                 32'hFFFF_F0FF, 64'h0);
    vecs[6] = mk(0, 0, 32'h7FFF_FFE4, 32'h0,        4'b0000, 3,  0, 5, 29'h1FFF_FFF8, '1,
                 64'h1E1E1E1E);
    vecs[7] = mk(1, 0, 32'h0000_0A0C, 32'h0,        4'b0000, 0,  0, 1, 29'h280,      '1,
                 64'h3C3C3C3C_2D2D2D2D);
    vecs[8] = mk(0, 0, 32'h0000_0003, 32'h0,        4'b0000, 0,  0, 0, 29'h0,        '1,
                 64'h0F0F0F0F);

    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    // Calibration pending: a held fetch request must not be granted.
    issue(vecs[0]);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("calib_wait_en", ddr_en, 1'b0);
    end
    init_calib_complete = 1'b1;
    service(vecs[0], 2);

    for (int i = 1; i < 9; i++) begin
      issue(vecs[i]);
      service(vecs[i], 1);
    end

    // Reset while waiting for read data: outputs clear at once, late data is ignored.
    issue(vecs[2]);
    n = 0;
    while (!ddr_en && n < 20) begin
      tick();
      n++;
    end
    chk("rst_seq_en", ddr_en, 1'b1);
    ddr_rdy = 1'b1;
    tick();
    ddr_rdy = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_reset("rst_rwait");
    e = sb.pop_back();
    mem_req = 1'b0;
    tick();
    rst_n = 1'b1;
    ddr_read_data = BEAT;
    ddr_read_data_valid = 1'b1;
    tick();
    ddr_read_data_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("late_valid_quiet", {if_ack, mem_ack, ddr_en}, 3'b000);
    end

    // Both ports held: fresh after reset MEM wins the first tie, then strict alternation.
    for (int i = 0; i < 4; i++) begin
      e.is_if = (i % 2 == 1);
      e.is_wr = 1'b0;
      e.data  = e.is_if ? vecs[3].exp_rdata : vecs[2].exp_rdata;
      sb.push_back(e);
    end
    if_addr = 32'h18; mem_addr = 32'h1C; mem_we = 1'b0;
    if_req = 1'b1; mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!ddr_en && n < 20) begin
        tick();
        n++;
      end
      chk("rr_en", ddr_en, 1'b1);
      chk("rr_addr", mem_addr_o, 29'h0);
      ddr_rdy = 1'b1;
      tick();
      ddr_rdy = 1'b0;
      ddr_read_data = BEAT;
      ddr_read_data_valid = 1'b1;
      tick();
      ddr_read_data_valid = 1'b0;
      chk("rr_grant", {if_ack, mem_ack}, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i == 3) begin
        if_req = 1'b0;
        mem_req = 1'b0;
      end
      tick();
    end

    // Calibration drop while idle parks the arbiter until it returns.
    init_calib_complete = 1'b0;
    tick();
    issue(vecs[7]);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("recal_wait_en", ddr_en, 1'b0);
    end
    init_calib_complete = 1'b1;
    service(vecs[7], 2);

    repeat (2) tick();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
